// File: rtl/spi_pkg.sv
// Shared definitions for the SPI serial-clock generator: FSM state
// encoding, SPI mode constants and default field widths.
package spi_pkg;

  // Default widths: half-period divisor and bits-per-transfer field.
  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 6;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // SPI modes encoded as {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // True when the mode samples MISO on the leading SCLK edge.
  function automatic logic samples_on_lead(input logic [1:0] mode);
    logic lead;
    case (mode)
      MODE0:   lead = 1'b1;
      MODE1:   lead = 1'b0;
      MODE2:   lead = 1'b1;
      MODE3:   lead = 1'b0;
      default: lead = 1'b1;
    endcase
    return lead;
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer for the SPI clock generator. Counts i_clk cycles
// from 0 up to i_limit and flags the cycle in which the count wraps, so
// the consumer can toggle SCLK on the following edge.
module spi_half_period_timer
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_limit,
  output logic             o_wrap
);

  logic [DIV_W-1:0] cnt_q;

  // Wrap is seen one cycle ahead so the registered SCLK toggles exactly
  // i_limit+1 cycles after the counter was cleared.
  assign o_wrap = i_en && !i_clear && (cnt_q == i_limit);

  // Half-period counter: cleared while not running, wraps at the limit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_en) begin
      if (cnt_q == i_limit) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator with runtime CPOL/CPHA, programmable bit
// count and divisor. Produces SCLK plus lead/trail edge pulses and
// sample/shift strobes for the shift-register datapath.
// Optional feature: define SPI_SCLK_ABORT_EN to add the i_abort input,
// which cancels a running transfer without a done pulse.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_cpol,
  input  logic             i_cpha,
  input  logic [CNT_W-1:0] i_nbits,
  input  logic             i_start,
`ifdef SPI_SCLK_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_ready,
  output logic             o_sclk,
  output logic             o_lead_edge,
  output logic             o_trail_edge,
  output logic             o_sample,
  output logic             o_shift,
  output logic [CNT_W-1:0] o_bit_count,
  output logic             o_done
);

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [CNT_W-1:0] nbits_q;
  logic [CNT_W:0]   edge_q;

  logic             abort_req;
  logic             cfg_acc;
  logic             start_acc;
  logic             wrap;
  logic             lead_now;
  logic             trail_now;
  logic             sample_now;
  logic             shift_now;
  logic             last_edge;
  logic [CNT_W:0]   edge_nxt;
  logic [DIV_W-1:0] div_limit;

`ifdef SPI_SCLK_ABORT_EN
  assign abort_req = i_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Config wins over start when both arrive in the same idle cycle.
  assign cfg_acc   = i_cfg_valid && o_ready;
  assign start_acc = i_start && o_ready && !i_cfg_valid;

  // Latched divisor is never zero, so limit = div-1 cannot underflow.
  assign div_limit = div_q - DIV_W'(1);

  spi_half_period_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (state_q != ST_RUN),
    .i_en    (state_q == ST_RUN),
    .i_limit (div_limit),
    .o_wrap  (wrap)
  );

  // Classify the upcoming SCLK toggle and map it onto sample/shift.
  always_comb begin
    lead_now   = wrap && (o_sclk == cpol_q);
    trail_now  = wrap && (o_sclk != cpol_q);
    if (samples_on_lead({cpol_q, cpha_q})) begin
      sample_now = lead_now;
      shift_now  = trail_now;
    end else begin
      sample_now = trail_now;
      shift_now  = lead_now;
    end
    edge_nxt  = edge_q + (CNT_W + 1)'(1);
    last_edge = wrap && (edge_nxt == {nbits_q, 1'b0});
  end

  // Transfer FSM with registered SCLK, strobes, bit counter and handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      div_q        <= DIV_W'(1);
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      nbits_q      <= '0;
      edge_q       <= '0;
      o_ready      <= 1'b1;
      o_sclk       <= 1'b0;
      o_lead_edge  <= 1'b0;
      o_trail_edge <= 1'b0;
      o_sample     <= 1'b0;
      o_shift      <= 1'b0;
      o_bit_count  <= '0;
      o_done       <= 1'b0;
    end else begin
      o_lead_edge  <= 1'b0;
      o_trail_edge <= 1'b0;
      o_sample     <= 1'b0;
      o_shift      <= 1'b0;
      o_done       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cfg_acc) begin
            div_q   <= (i_div == '0) ? DIV_W'(1) : i_div;
            cpol_q  <= i_cpol;
            cpha_q  <= i_cpha;
            nbits_q <= i_nbits;
            o_sclk  <= i_cpol;
          end else if (start_acc) begin
            o_ready     <= 1'b0;
            o_bit_count <= '0;
            edge_q      <= '0;
            if (nbits_q == '0) begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort_req) begin
            state_q <= ST_IDLE;
            o_ready <= 1'b1;
            o_sclk  <= cpol_q;
          end else if (wrap) begin
            o_sclk       <= ~o_sclk;
            o_lead_edge  <= lead_now;
            o_trail_edge <= trail_now;
            o_sample     <= sample_now;
            o_shift      <= shift_now;
            edge_q       <= edge_nxt;
            if (sample_now) begin
              o_bit_count <= o_bit_count + CNT_W'(1);
            end
            if (last_edge) begin
              state_q <= ST_DONE;
              o_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          o_ready <= 1'b1;
          o_sclk  <= cpol_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Directed testbench for spi_sclk_gen (default widths). Define
// SPI_SCLK_ABORT_EN to include the abort scenario.
module tb_spi_sclk_gen;

  localparam int DIV_W = 8;
  localparam int CNT_W = 6;

  logic             i_clk;
  logic             i_rst;
  logic             i_cfg_valid;
  logic [DIV_W-1:0] i_div;
  logic             i_cpol;
  logic             i_cpha;
  logic [CNT_W-1:0] i_nbits;
  logic             i_start;
`ifdef SPI_SCLK_ABORT_EN
  logic             i_abort;
`endif
  logic             o_ready;
  logic             o_sclk;
  logic             o_lead_edge;
  logic             o_trail_edge;
  logic             o_sample;
  logic             o_shift;
  logic [CNT_W-1:0] o_bit_count;
  logic             o_done;

  int n_checks = 0;
  int n_errors = 0;

  spi_sclk_gen #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cfg_valid  (i_cfg_valid),
    .i_div        (i_div),
    .i_cpol       (i_cpol),
    .i_cpha       (i_cpha),
    .i_nbits      (i_nbits),
    .i_start      (i_start),
`ifdef SPI_SCLK_ABORT_EN
    .i_abort      (i_abort),
`endif
    .o_ready      (o_ready),
    .o_sclk       (o_sclk),
    .o_lead_edge  (o_lead_edge),
    .o_trail_edge (o_trail_edge),
    .o_sample     (o_sample),
    .o_shift      (o_shift),
    .o_bit_count  (o_bit_count),
    .o_done       (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Write one configuration word; returns at the next falling edge.
  task automatic cfg(input int dv, input bit cp, input bit ch, input int nb);
    i_div       = dv[DIV_W-1:0];
    i_cpol      = cp;
    i_cpha      = ch;
    i_nbits     = nb[CNT_W-1:0];
    i_cfg_valid = 1'b1;
    @(negedge i_clk);
    i_cfg_valid = 1'b0;
  endtask

  // Start a transfer and observe it until o_ready returns. n counts
  // rising edges after the one that accepted the start.
  task automatic xfer(input string tag, input int dv, input bit cp, input bit ch,
                      input int nb, input bit cfg_mid);
    int n_lead = 0, n_trail = 0, n_samp = 0, n_shift = 0, n_done = 0;
    int done_n = -1, ready_n = -1, first = -1, bad_samp = 0, bad_shift = 0, bad_space = 0;
    int exp_first;
    logic sclk_end = 1'bx;
    logic [CNT_W-1:0] cnt_end = '0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) @(negedge i_clk);
      if (cfg_mid && n == 2) begin
        i_div = 8'd5; i_cpol = 1'b1; i_cpha = 1'b1; i_nbits = 6'd3;
        i_cfg_valid = 1'b1;
      end else begin
        i_cfg_valid = 1'b0;
      end
      if (o_lead_edge) begin
        n_lead++;
        if (first < 0) first = n;
      end
      if (o_trail_edge) n_trail++;
      if ((o_lead_edge || o_trail_edge) && (n % dv != 0)) bad_space++;
      if (o_sample) begin
        n_samp++;
        if (o_sclk != (ch ? cp : !cp)) bad_samp++;
      end
      if (o_shift) begin
        n_shift++;
        if (o_sclk != (ch ? !cp : cp)) bad_shift++;
      end
      if (o_done) begin
        n_done++;
        done_n = n;
      end
      if (o_ready) begin
        ready_n  = n;
        sclk_end = o_sclk;
        cnt_end  = o_bit_count;
        break;
      end
    end
    i_cfg_valid = 1'b0;
    exp_first = (nb == 0) ? -1 : dv;
    check({tag, ".lead"},      n_lead,    nb);
    check({tag, ".trail"},     n_trail,   nb);
    check({tag, ".sample"},    n_samp,    nb);
    check({tag, ".shift"},     n_shift,   nb);
    check({tag, ".done_cnt"},  n_done,    1);
    check({tag, ".done_at"},   done_n,    2 * nb * dv);
    check({tag, ".ready_at"},  ready_n,   2 * nb * dv + 1);
    check({tag, ".first_edge"}, first,    exp_first);
    check({tag, ".spacing"},   bad_space, 0);
    check({tag, ".samp_lvl"},  bad_samp,  0);
    check({tag, ".shift_lvl"}, bad_shift, 0);
    check({tag, ".sclk_end"},  sclk_end,  cp);
    check({tag, ".bit_count"}, cnt_end,   nb);
  endtask

  initial begin
    logic [7:0] rdy_v;
    logic [7:0] dn_v;
    int         dn_cnt;

    i_rst = 1'b1; i_cfg_valid = 1'b0; i_div = '0; i_cpol = 1'b0;
    i_cpha = 1'b0; i_nbits = '0; i_start = 1'b0;
`ifdef SPI_SCLK_ABORT_EN
    i_abort = 1'b0;
`endif
    repeat (3) @(negedge i_clk);
    check("rst.ready", o_ready, 1);
    check("rst.sclk",  o_sclk,  0);
    check("rst.strb",  {o_lead_edge, o_trail_edge, o_sample, o_shift}, 0);
    check("rst.count", o_bit_count, 0);
    check("rst.done",  o_done, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst.ready", o_ready, 1);

    // Mode 0 at the fastest rate.
    cfg(1, 1'b0, 1'b0, 8);
    check("m0.idle_sclk", o_sclk, 0);
    xfer("m0", 1, 1'b0, 1'b0, 8, 1'b0);

    // Mode 3, divisor 3: SCLK idles high.
    cfg(3, 1'b1, 1'b1, 4);
    check("m3.idle_sclk", o_sclk, 1);
    xfer("m3", 3, 1'b1, 1'b1, 4, 1'b0);

    // Config and start together: config taken, start dropped.
    i_div = 8'd2; i_cpol = 1'b0; i_cpha = 1'b0; i_nbits = 6'd2;
    i_cfg_valid = 1'b1; i_start = 1'b1;
    @(negedge i_clk);
    i_cfg_valid = 1'b0; i_start = 1'b0;
    check("cs.ready", o_ready, 1);
    check("cs.sclk",  o_sclk,  0);
    @(negedge i_clk);
    check("cs.still_ready", o_ready, 1);
    // Config written mid-run must not disturb this or the next transfer.
    xfer("cs_run", 2, 1'b0, 1'b0, 2, 1'b1);
    xfer("cs_after", 2, 1'b0, 1'b0, 2, 1'b0);

    // Zero-bit transfer: straight to done.
    cfg(4, 1'b0, 1'b1, 0);
    xfer("nb0", 4, 1'b0, 1'b1, 0, 1'b0);

    // Divisor 0 behaves as divisor 1.
    cfg(0, 1'b0, 1'b0, 3);
    xfer("div0", 1, 1'b0, 1'b0, 3, 1'b0);

    // Start held high: back-to-back 1-bit transfers, one idle cycle apart.
    cfg(1, 1'b0, 1'b0, 1);
    i_start = 1'b1;
    @(negedge i_clk);
    for (int n = 0; n < 8; n++) begin
      if (n > 0) @(negedge i_clk);
      rdy_v[n] = o_ready;
      dn_v[n]  = o_done;
    end
    i_start = 1'b0;
    check("b2b.ready_pat", rdy_v, 8'h88);
    check("b2b.done_pat",  dn_v,  8'h44);
    @(negedge i_clk);
    check("b2b.idle", o_ready, 1);

    // Asynchronous reset in the middle of a transfer.
    cfg(1, 1'b0, 1'b0, 8);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (5) @(negedge i_clk);
    check("mrst.sclk_before",  o_sclk, 1);
    check("mrst.count_before", o_bit_count, 3);
    #2 i_rst = 1'b1;
    #1;
    check("mrst.sclk",  o_sclk, 0);
    check("mrst.ready", o_ready, 1);
    check("mrst.count", o_bit_count, 0);
    check("mrst.done",  o_done, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    dn_cnt = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_done) dn_cnt++;
    end
    check("mrst.no_done", dn_cnt, 0);
    check("mrst.ready_after", o_ready, 1);

`ifdef SPI_SCLK_ABORT_EN
    begin
      bit found = 1'b0;
      cfg(2, 1'b1, 1'b0, 8);
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      for (int n = 0; n < 100; n++) begin
        if (o_bit_count == 6'd3) begin
          found = 1'b1;
          break;
        end
        @(negedge i_clk);
      end
      check("ab.reached3", found, 1);
      i_abort = 1'b1;
      @(negedge i_clk);
      i_abort = 1'b0;
      check("ab.ready", o_ready, 1);
      check("ab.sclk",  o_sclk,  1);
      check("ab.count", o_bit_count, 3);
      check("ab.strb",  {o_lead_edge, o_trail_edge, o_sample, o_shift}, 0);
      dn_cnt = 0;
      repeat (10) begin
        if (o_done) dn_cnt++;
        @(negedge i_clk);
      end
      check("ab.no_done", dn_cnt, 0);
      check("ab.count_held", o_bit_count, 3);
      xfer("ab_full", 2, 1'b1, 1'b0, 8, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_sclk_gen.md
Name: spi_sclk_gen

Overview:
Parametrised SPI serial-clock generator; successor to the fixed 8-bit clock divider. It adds runtime SPI mode (CPOL/CPHA), a programmable bit count per transfer and generic divisor width. It also emits sample/shift strobes, so the shift-register datapath needs no edge decoding. It sits between the SPI controller FSM and the shift registers and drives the SCLK pad.

Parameters:
DIV_W, 8, width of half-period divisor
CNT_W, 6, width of bit-count field (max transfer 2^CNT_W-1 bits)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_cfg_valid  in  1  config write request
i_div  in  DIV_W  SCLK half-period in i_clk cycles (0 treated as 1)
i_cpol  in  1  SCLK idle level
i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
i_nbits  in  CNT_W  bits per transfer
i_start  in  1  start-transfer request
o_ready  out  1  idle, accepts config/start
o_sclk  out  1  serial clock
o_lead_edge  out  1  pulse: SCLK left idle level this cycle
o_trail_edge  out  1  pulse: SCLK returned to idle level this cycle
o_sample  out  1  pulse: MISO sample point
o_shift  out  1  pulse: MOSI update point
o_bit_count  out  CNT_W  bits sampled so far
o_done  out  1  one-cycle end-of-transfer pulse

Behaviour:
- Reset (async): state IDLE; div=1, cpol=0, cpha=0, nbits=0. Outputs: o_ready=1, o_sclk=0, all strobes 0, o_bit_count=0.
- States: IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
- Config: i_cfg_valid&&o_ready latches div/cpol/cpha/nbits at that edge. o_sclk moves to the new cpol on the same edge. Config is ignored outside IDLE.
- Start: i_start&&o_ready&&!i_cfg_valid enters RUN. If config and start are asserted together, config wins and start is dropped.
- Start with latched nbits=0: IDLE->DONE, no edges, o_done pulses next cycle.
- RUN: the half-period counter clears on entry and increments each cycle. When it equals div-1, it wraps to 0, o_sclk toggles and exactly one of lead/trail pulses with the toggle.
- Edge timing: start accepted at edge k gives SCLK edges at k+div, k+2*div, ... k+2*nbits*div. Fastest SCLK is f_clk/2 (div=1).
- Strobes: cpha=0 gives sample=lead, shift=trail. cpha=1 gives sample=trail, shift=lead. Both pulse coincident with the edge.
- o_bit_count increments on each sample pulse. It holds its final value through DONE and clears on the next accepted start.
- After edge 2*nbits, the state goes to DONE. o_sclk is at cpol. o_done is high for exactly one cycle, then IDLE with o_ready=1. The start->o_ready round trip is 2*nbits*div+1 edges.
- Transitions: start and config do not change state outside IDLE. i_start held high re-arms immediately after DONE (back-to-back transfers, one idle cycle between).
- Reset mid-transfer: immediate return to reset values, no o_done.

Optional Feature:
- Macro: SPI_SCLK_ABORT_EN.
- With the macro: adds port i_abort (in, 1). i_abort in RUN returns to IDLE next edge, with o_sclk=cpol, strobes 0, no o_done and o_bit_count held. i_abort in IDLE/DONE is ignored.
- Without the macro: the port is absent and transfers always run to completion.

Decomposition:
- Package spi_pkg holds:
  - state encoding enum (IDLE/RUN/DONE)
  - CPOL/CPHA mode constants (MODE0..MODE3)
  - default DIV_W/CNT_W localparams
- Sub-module spi_half_period_timer (DIV_W counter, clear/enable in, wrap pulse out) is natural; the top keeps FSM, edge/bit counters and strobe logic.

Test Plan:
- Reset, config div=1, cpol=0, cpha=0, nbits=8, start: 16 edges at 1-cycle spacing, 8 sample pulses on rising edges, o_bit_count=8, o_done once, o_ready back 17 edges after start.
- Config div=3, cpol=1, cpha=1, nbits=4: o_sclk idles 1, edges every 3 cycles, sample on rising (trailing) edges, shift on falling, 24-cycle run.
- Config and start asserted same cycle: config latched, no transfer. Start next cycle uses new div. Config during RUN is ignored (div unchanged).
- nbits=0 start: no SCLK activity, o_done pulses once next cycle. div=0: behaves identically to div=1.
- i_rst asserted mid-transfer at edge 5: o_sclk=0, o_ready=1, o_bit_count=0 immediately, no o_done.
- SPI_SCLK_ABORT_EN defined: abort after 3 samples: o_bit_count=3 held, o_sclk=cpol, no o_done. Next start runs a full nbits transfer.
